frac_search_ctrl: RTL and testbench

//  Sequencer for one frac_search datapath. On start, streams the 8x8 current block and NUM_CAND

---
 rtl/frac_search_pkg.sv | 15 +
 rtl/frac_search_ctrl_if.sv | 30 +++
 rtl/frac_best_tracker.sv | 46 ++++
 rtl/frac_search_ctrl.sv | 131 +++++++++++++
 tb/tb_frac_search_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frac_search_pkg.sv
// Shared types and constants for the frac_search sequencer.
package frac_search_pkg;
  localparam int ROWS        = 8;
  localparam int FEED_CYCLES = 9;
  localparam int SAD_W       = 12;
  localparam int MV_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_WAIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/frac_search_ctrl_if.sv
// Row-buffer read ports and frac_search datapath link of one sequencer.
interface frac_search_ctrl_if #(parameter int CAND_W = 2);
  import frac_search_pkg::*;

  logic              cur_rd_en;
  logic [2:0]        cur_rd_addr;
  logic [63:0]       cur_rd_data;
  logic              org_rd_en;
  logic [CAND_W+2:0] org_rd_addr;
  logic [63:0]       org_rd_data;
  logic [63:0]       fs_cur_pix;
  logic [55:8]       fs_org_pix;
  logic              fs_ready;
  logic              fs_reset;
  logic [SAD_W-1:0]  fs_sad;
  logic [MV_W-1:0]   fs_mvx;
  logic [MV_W-1:0]   fs_mvy;

  modport master (
    output cur_rd_en, cur_rd_addr, org_rd_en, org_rd_addr,
    output fs_cur_pix, fs_org_pix, fs_ready, fs_reset,
    input  cur_rd_data, org_rd_data, fs_sad, fs_mvx, fs_mvy
  );

  modport slave (
    input  cur_rd_en, cur_rd_addr, org_rd_en, org_rd_addr,
    input  fs_cur_pix, fs_org_pix, fs_ready, fs_reset,
    output cur_rd_data, org_rd_data, fs_sad, fs_mvx, fs_mvy
  );
endinterface

// File: rtl/frac_best_tracker.sv
// Running-minimum SAD tracker. nxt_* is the value the registers take this edge,
// so a result sampled on the final edge is already visible to the caller.
module frac_best_tracker
  import frac_search_pkg::*;
#(
  parameter int CAND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_first,
  input  logic              sample,
  input  logic [SAD_W-1:0]  sad,
  input  logic [MV_W-1:0]   mvx,
  input  logic [MV_W-1:0]   mvy,
  input  logic [CAND_W-1:0] cand,
  output logic [SAD_W-1:0]  nxt_sad,
  output logic [MV_W-1:0]   nxt_mvx,
  output logic [MV_W-1:0]   nxt_mvy,
  output logic [CAND_W-1:0] nxt_cand
);
  logic [SAD_W-1:0]  run_sad;
  logic [MV_W-1:0]   run_mvx, run_mvy;
  logic [CAND_W-1:0] run_cand;
  logic              capture;

  // strict compare: ties keep the earlier candidate
  assign capture  = sample && (clear_first || (sad < run_sad));
  assign nxt_sad  = capture ? sad  : run_sad;
  assign nxt_mvx  = capture ? mvx  : run_mvx;
  assign nxt_mvy  = capture ? mvy  : run_mvy;
  assign nxt_cand = capture ? cand : run_cand;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_sad  <= '0;
      run_mvx  <= '0;
      run_mvy  <= '0;
      run_cand <= '0;
    end else begin
      run_sad  <= nxt_sad;
      run_mvx  <= nxt_mvx;
      run_mvy  <= nxt_mvy;
      run_cand <= nxt_cand;
    end
  end
endmodule

// File: rtl/frac_search_ctrl.sv
// Sequencer feeding the current block and NUM_CAND org windows into one frac_search
// datapath, keeping the best (minimum SAD) candidate and reporting it with a done pulse.
module frac_search_ctrl
  import frac_search_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int CAND_W     = 2,
  parameter int RESULT_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  frac_search_ctrl_if.master fs,
  output logic [SAD_W-1:0]   best_sad,
  output logic [MV_W-1:0]    best_mvx,
  output logic [MV_W-1:0]    best_mvy,
  output logic [CAND_W-1:0]  best_cand
);
  localparam int         LAT_W    = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [3:0] LAST_CNT = 4'(FEED_CYCLES - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_t            state, nxt;
  logic [CAND_W-1:0] cand;
  logic [3:0]        cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              last_wait, last_cand, fs_reset_q;
  logic [SAD_W-1:0]  nxt_sad;
  logic [MV_W-1:0]   nxt_mvx, nxt_mvy;
  logic [CAND_W-1:0] nxt_cand;
  logic              unused_org;

  assign last_wait   = (state == ST_WAIT) && (lat_cnt == LAT_W'(RESULT_LAT - 1));
  assign last_cand   = (cand == CAND_W'(NUM_CAND - 1));
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign fs.fs_reset = fs_reset_q;
  assign unused_org  = ^{fs.org_rd_data[63:56], fs.org_rd_data[7:0]};

  frac_best_tracker #(.CAND_W(CAND_W)) u_best (
    .clk        (clk),
    .reset      (reset),
    .clear_first(cand == '0),
    .sample     (last_wait),
    .sad        (fs.fs_sad),
    .mvx        (fs.fs_mvx),
    .mvy        (fs.fs_mvy),
    .cand       (cand),
    .nxt_sad    (nxt_sad),
    .nxt_mvx    (nxt_mvx),
    .nxt_mvy    (nxt_mvy),
    .nxt_cand   (nxt_cand)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cand       <= '0;
      cnt        <= '0;
      lat_cnt    <= '0;
      fs_reset_q <= 1'b0;
      best_sad   <= '0;
      best_mvx   <= '0;
      best_mvy   <= '0;
      best_cand  <= '0;
    end else begin
      state      <= nxt;
      fs_reset_q <= (nxt == ST_CLEAR);
      case (state)
        ST_CLEAR: cnt <= '0;
        ST_FEED: begin
          if (cnt != LAST_CNT) cnt <= cnt + 4'd1;
          lat_cnt <= '0;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (last_wait && !last_cand) cand <= cand + CAND_W'(1);
        end
        ST_DONE: cand <= '0;
        default: ;
      endcase
      // last sample lands on this same edge, so take the tracker's next values
      if (last_wait && last_cand) begin
        best_sad  <= nxt_sad;
        best_mvx  <= nxt_mvx;
        best_mvy  <= nxt_mvy;
        best_cand <= nxt_cand;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_CLEAR;
      ST_CLEAR: nxt = ST_FEED;
      ST_FEED:  if (cnt == LAST_CNT) nxt = ST_WAIT;
      ST_WAIT:  if (last_wait) nxt = last_cand ? ST_DONE : ST_CLEAR;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // org data lags cur data by one row; row 7 is read twice so it is held for the final feed
  always_comb begin
    fs.cur_rd_en   = 1'b0;
    fs.cur_rd_addr = '0;
    fs.org_rd_en   = 1'b0;
    fs.org_rd_addr = '0;
    fs.fs_cur_pix  = '0;
    fs.fs_org_pix  = '0;
    fs.fs_ready    = 1'b0;
    case (state)
      ST_CLEAR: fs.cur_rd_en = 1'b1;
      ST_FEED: begin
        fs.cur_rd_en   = 1'b1;
        fs.cur_rd_addr = (cnt >= LAST_ROW) ? 3'(LAST_ROW) : cnt[2:0] + 3'd1;
        fs.fs_ready    = 1'b1;
        fs.fs_cur_pix  = fs.cur_rd_data;
        if (cnt <= LAST_ROW) begin
          fs.org_rd_en   = 1'b1;
          fs.org_rd_addr = {cand, cnt[2:0]};
        end
        if (cnt != 4'd0) fs.fs_org_pix = fs.org_rd_data[55:8];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_frac_search_ctrl.sv
// Directed bench for frac_search_ctrl: row-buffer and frac_search models, default and short configs.
module tb_frac_search_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start2;
  logic        busy, done, busy2, done2;
  logic [11:0] best_sad, best_sad2;
  logic [2:0]  best_mvx, best_mvy, best_mvx2, best_mvy2;
  logic [1:0]  best_cand;
  logic [0:0]  best_cand2;

  int checks = 0;
  int errors = 0;

  frac_search_ctrl_if #(.CAND_W(2)) bus ();
  frac_search_ctrl_if #(.CAND_W(1)) bus2 ();

  frac_search_ctrl #(.NUM_CAND(4), .CAND_W(2), .RESULT_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fs(bus),
    .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy), .best_cand(best_cand)
  );

  frac_search_ctrl #(.NUM_CAND(1), .CAND_W(1), .RESULT_LAT(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .fs(bus2),
    .best_sad(best_sad2), .best_mvx(best_mvx2), .best_mvy(best_mvy2), .best_cand(best_cand2)
  );

  function automatic logic [63:0] cur_row(input int r);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(8*r + i);
    return v;
  endfunction

  function automatic logic [63:0] org_row(input int c, input int r);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(64*c + 8*r + i);
    return v;
  endfunction

  // row buffers (1-cycle read) and a frac_search stand-in keyed on the candidate being fed
  logic [11:0] sad_tab [0:3];
  logic [2:0]  mvx_tab [0:3];
  logic [2:0]  mvy_tab [0:3];
  logic [1:0]  mc;
  logic [7:0]  cyc2;

  always @(posedge clk) begin
    if (reset) begin
      bus.cur_rd_data <= '0;
      bus.org_rd_data <= '0;
      mc              <= '0;
    end else begin
      if (bus.cur_rd_en) bus.cur_rd_data <= cur_row(int'(bus.cur_rd_addr));
      if (bus.org_rd_en) begin
        bus.org_rd_data <= org_row(int'(bus.org_rd_addr[4:3]), int'(bus.org_rd_addr[2:0]));
        mc              <= bus.org_rd_addr[4:3];
      end
    end
  end
  assign bus.fs_sad = sad_tab[mc];
  assign bus.fs_mvx = mvx_tab[mc];
  assign bus.fs_mvy = mvy_tab[mc];

  // short config: SAD tracks the cycle count so the sampling cycle is visible in best_sad
  always @(posedge clk) cyc2 <= (reset || start2) ? 8'd0 : cyc2 + 8'd1;
  assign bus2.cur_rd_data = '0;
  assign bus2.org_rd_data = '0;
  assign bus2.fs_sad      = {4'h0, cyc2};
  assign bus2.fs_mvx      = 3'd5;
  assign bus2.fs_mvy      = 3'd6;

  task automatic set_tab(input logic [11:0] s0, s1, s2, s3, input logic [2:0] x0, x1, x2, x3,
                         input logic [2:0] y0, y1, y2, y3);
    sad_tab[0] = s0; sad_tab[1] = s1; sad_tab[2] = s2; sad_tab[3] = s3;
    mvx_tab[0] = x0; mvx_tab[1] = x1; mvx_tab[2] = x2; mvx_tab[3] = x3;
    mvy_tab[0] = y0; mvy_tab[1] = y1; mvy_tab[2] = y2; mvy_tab[3] = y3;
  endtask

  // one full run; m counts cycles after the edge that samples start
  task automatic run(input int p1, input int p2, input bit chk, output int lat, output int nd);
    logic [63:0] tmp;
    logic [55:8] exp_org;
    logic [63:0] exp_cur;
    int c, p, k;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; nd = 0;
    for (int m = 0; m <= 60; m++) begin
      if (m > 0) begin @(posedge clk); #1; end
      start = (m == p1) || (m == p2);
      if (done) begin nd++; if (lat < 0) lat = m; end
      checks++;
      if (busy !== (m <= 44)) begin
        errors++; $display("FAIL busy m=%0d got %b exp %b", m, busy, (m <= 44));
      end
      if (chk && m < 44) begin
        c = m / 11; p = m % 11; k = p - 1;
        exp_cur = '0; exp_org = '0;
        if (p >= 1 && p <= 9) exp_cur = cur_row(k > 7 ? 7 : k);
        if (p >= 2 && p <= 9) begin tmp = org_row(c, k - 1); exp_org = tmp[55:8]; end
        checks += 4;
        if (bus.fs_reset !== (p == 0)) begin
          errors++; $display("FAIL fs_reset m=%0d got %b exp %b", m, bus.fs_reset, (p == 0));
        end
        if (bus.fs_ready !== (p >= 1 && p <= 9)) begin
          errors++; $display("FAIL fs_ready m=%0d got %b", m, bus.fs_ready);
        end
        if (bus.fs_cur_pix !== exp_cur) begin
          errors++; $display("FAIL cur_pix m=%0d got %h exp %h", m, bus.fs_cur_pix, exp_cur);
        end
        if (bus.fs_org_pix !== exp_org) begin
          errors++; $display("FAIL org_pix m=%0d got %h exp %h", m, bus.fs_org_pix, exp_org);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_best(input string nm, input logic [11:0] s, input logic [2:0] x, y,
                          input logic [1:0] cd);
    checks++;
    if ({best_sad, best_mvx, best_mvy, best_cand} !== {s, x, y, cd}) begin
      errors++;
      $display("FAIL %s best got sad=%0d mv=%0d/%0d cand=%0d exp sad=%0d mv=%0d/%0d cand=%0d",
               nm, best_sad, best_mvx, best_mvy, best_cand, s, x, y, cd);
    end
  endtask

  task automatic chk_run(input string nm, input int lat, input int nd);
    checks += 2;
    if (lat != 44) begin errors++; $display("FAIL %s latency got %0d exp 44", nm, lat); end
    if (nd != 1)   begin errors++; $display("FAIL %s done count got %0d exp 1", nm, nd); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks += 3;
    if ({busy, done, busy2, done2} !== 4'b0) begin
      errors++; $display("FAIL reset status got %b exp 0000", {busy, done, busy2, done2});
    end
    if ({bus.cur_rd_en, bus.org_rd_en, bus.fs_ready, bus.fs_reset} !== 4'b0) begin
      errors++; $display("FAIL reset ctrl got %b exp 0000",
                         {bus.cur_rd_en, bus.org_rd_en, bus.fs_ready, bus.fs_reset});
    end
    if ({best_sad, best_mvx, best_mvy, best_cand, bus.fs_cur_pix} !== '0) begin
      errors++; $display("FAIL reset outputs got sad=%0d cand=%0d", best_sad, best_cand);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_stream();
    int lat, nd;
    set_tab(12'd400, 12'd300, 12'd200, 12'd100, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd2, 3'd4, 3'd5);
    run(-1, -1, 1'b1, lat, nd);
    chk_run("stream", lat, nd);
    chk_best("stream", 12'd100, 3'd7, 3'd5, 2'd3);
  endtask

  task automatic test_tie();
    int lat, nd;
    set_tab(12'd300, 12'd120, 12'd120, 12'd500, 3'd1, 3'd2, 3'd5, 3'd0, 3'd2, 3'd3, 3'd5, 3'd0);
    run(-1, -1, 1'b0, lat, nd);
    chk_run("tie", lat, nd);
    chk_best("tie", 12'd120, 3'd2, 3'd3, 2'd1);
  endtask

  task automatic test_all_max();
    int lat, nd;
    set_tab(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 3'd1, 3'd2, 3'd5, 3'd0, 3'd2, 3'd3, 3'd5, 3'd1);
    run(-1, -1, 1'b0, lat, nd);
    chk_run("allmax", lat, nd);
    chk_best("allmax", 12'hFFF, 3'd1, 3'd2, 2'd0);
  endtask

  task automatic test_start_busy();
    int lat, nd;
    set_tab(12'd50, 12'd40, 12'd60, 12'd45, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1);
    run(5, 20, 1'b0, lat, nd);
    chk_run("busy_start", lat, nd);
    run(44, -1, 1'b0, lat, nd);
    chk_run("done_start", lat, nd);
    chk_best("back_to_back", 12'd40, 3'd2, 3'd3, 2'd1);
  endtask

  task automatic test_reset_mid_run();
    int lat, nd, nb;
    set_tab(12'd120, 12'd130, 12'd140, 12'd150, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd5, 3'd6);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (25) @(posedge clk); #1;
    checks++;
    if (!(bus.fs_ready === 1'b1 && bus.org_rd_addr[4:3] === 2'd2)) begin
      errors++; $display("FAIL midrun pos got ready=%b addr=%h exp ready=1 cand=2",
                         bus.fs_ready, bus.org_rd_addr);
    end
    reset = 1'b1; #1;
    checks += 2;
    if ({busy, done, bus.cur_rd_en, bus.org_rd_en, bus.fs_ready} !== 5'b0) begin
      errors++; $display("FAIL midrun reset got %b exp 00000",
                         {busy, done, bus.cur_rd_en, bus.org_rd_en, bus.fs_ready});
    end
    if ({best_sad, best_cand} !== '0) begin
      errors++; $display("FAIL midrun best clear got sad=%0d cand=%0d exp 0", best_sad, best_cand);
    end
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b0;
    nd = 0; nb = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (busy) nb++;
    end
    checks++;
    if (nd != 0 || nb != 0) begin
      errors++; $display("FAIL after reset got done=%0d busy=%0d exp 0/0", nd, nb);
    end
    run(-1, -1, 1'b0, lat, nd);
    chk_run("post_reset", lat, nd);
    chk_best("post_reset", 12'd120, 3'd2, 3'd3, 2'd0);
  endtask

  task automatic test_short_cfg();
    int lat, nr, nrdy;
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    lat = -1; nr = 0; nrdy = 0;
    for (int m = 0; m <= 30; m++) begin
      if (m > 0) begin @(posedge clk); #1; end
      if (bus2.fs_reset) nr++;
      if (bus2.fs_ready) nrdy++;
      if (done2 && lat < 0) lat = m;
    end
    checks += 4;
    if (lat != 13) begin errors++; $display("FAIL short latency got %0d exp 13", lat); end
    if (nr != 1)   begin errors++; $display("FAIL short fs_reset count got %0d exp 1", nr); end
    if (nrdy != 9) begin errors++; $display("FAIL short ready cycles got %0d exp 9", nrdy); end
    if ({best_sad2, best_mvx2, best_mvy2, best_cand2} !== {12'd12, 3'd5, 3'd6, 1'b0}) begin
      errors++; $display("FAIL short best got sad=%0d mv=%0d/%0d cand=%0d exp 12 5/6 0",
                         best_sad2, best_mvx2, best_mvy2, best_cand2);
    end
  endtask

  initial begin
    set_tab(12'd0, 12'd0, 12'd0, 12'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    test_reset();
    test_stream();
    test_tie();
    test_all_max();
    test_start_busy();
    test_reset_mid_run();
    test_short_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
